// File: rtl/main.sv
// Word-guessing game controller: debounced host/player keypads, SETUP/PLAY/WIN/LOSE
// state machine and four 16-character ASCII display rows decoded from registered state.
module main (
    input  logic         clk,
    input  logic         nRst,
    input  logic         role_switch,
    input  logic [3:0]   input_row_host,
    input  logic [3:0]   input_row_player,
    input  logic         error,
    input  logic         red,
    input  logic         green,
    input  logic         blue,
    output logic [127:0] host_row1,
    output logic [127:0] host_row2,
    output logic [127:0] play_row1,
    output logic [127:0] play_row2
);

    localparam int unsigned KEY_W    = 4;
    localparam int unsigned NUM_BUS  = 2;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned DEB_CYC  = 16;
    localparam int unsigned LTR_W    = 5;
    localparam int unsigned NUM_LTR  = 26;
    localparam int unsigned MAX_LEN  = 8;
    localparam int unsigned LEN_W    = 4;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned MISS_W   = 3;
    localparam int unsigned MAX_MISS = 6;
    localparam int unsigned ROW_W    = 128;

    localparam int unsigned KEY_UP    = 3;
    localparam int unsigned KEY_DOWN  = 2;
    localparam int unsigned KEY_WORD  = 1;
    localparam int unsigned KEY_ENTER = 0;

    typedef enum logic [1:0] {
        ST_SETUP = 2'd0,
        ST_PLAY  = 2'd1,
        ST_WIN   = 2'd2,
        ST_LOSE  = 2'd3
    } state_e;

    // LED feedback inputs are reserved and intentionally unused.
    logic unused_leds;
    assign unused_leds = red ^ green ^ blue;

    // Debounce state, indexed by physical bus (0 = host pins, 1 = player pins).
    logic [NUM_BUS-1:0][KEY_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_BUS-1:0][KEY_W-1:0] last_q, last_d, evt_q, evt_d;
    logic [NUM_BUS-1:0][CNT_W-1:0] cnt_q, cnt_d, run;
    logic [NUM_BUS-1:0]            armed_q, armed_d;

    always_comb begin
        sync1_d[0] = input_row_host;
        sync1_d[1] = input_row_player;
        sync2_d    = sync1_q;
        last_d     = sync2_q;
        cnt_d      = cnt_q;
        armed_d    = armed_q;
        evt_d      = '0;
        run        = '0;
        for (int b = 0; b < int'(NUM_BUS); b++) begin
            // run = length of the current stable streak including this cycle
            run[b] = ((sync2_q[b] == last_q[b]) && (cnt_q[b] != '0)) ?
                     CNT_W'(cnt_q[b] + 1'b1) : CNT_W'(1);
            if (armed_q[b]) begin
                if ($onehot(sync2_q[b])) begin
                    if (run[b] == CNT_W'(DEB_CYC)) begin
                        evt_d[b]   = sync2_q[b];
                        armed_d[b] = 1'b0;
                        cnt_d[b]   = '0;
                    end else begin
                        cnt_d[b] = run[b];
                    end
                end else begin
                    cnt_d[b] = '0;
                end
            end else begin
                if (sync2_q[b] == '0) begin
                    if (run[b] == CNT_W'(DEB_CYC)) begin
                        armed_d[b] = 1'b1;
                        cnt_d[b]   = '0;
                    end else begin
                        cnt_d[b] = run[b];
                    end
                end else begin
                    cnt_d[b] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            last_q  <= '0;
            evt_q   <= '0;
            cnt_q   <= '0;
            armed_q <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            last_q  <= last_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    // Roles are resolved when the event is applied, not when the press started.
    logic [KEY_W-1:0] h_evt, p_evt;
    assign h_evt = role_switch ? evt_q[1] : evt_q[0];
    assign p_evt = role_switch ? evt_q[0] : evt_q[1];

    function automatic logic [LTR_W-1:0] ltr_inc(input logic [LTR_W-1:0] x);
        return (x == LTR_W'(NUM_LTR - 1)) ? '0 : LTR_W'(x + 1'b1);
    endfunction

    function automatic logic [LTR_W-1:0] ltr_dec(input logic [LTR_W-1:0] x);
        return (x == '0) ? LTR_W'(NUM_LTR - 1) : LTR_W'(x - 1'b1);
    endfunction

    function automatic logic [7:0] ascii(input logic [LTR_W-1:0] x);
        return 8'(8'h41 + {3'b000, x});
    endfunction

    state_e                        state_q, state_d;
    logic [MAX_LEN-1:0][LTR_W-1:0] word_q, word_d;
    logic [LEN_W-1:0]              len_q, len_d;
    logic [MISS_W-1:0]             miss_q, miss_d;
    logic [NUM_LTR-1:0]            guessed_q, guessed_d;
    logic [LTR_W-1:0]              hcand_q, hcand_d, pcand_q, pcand_d;
    logic                          do_clear;
    logic                          in_word, all_rev;

    always_comb begin
        in_word = 1'b0;
        all_rev = 1'b1;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (LEN_W'(i) < len_q) begin
                if (word_q[i] == pcand_q) in_word = 1'b1;
                if (!guessed_q[word_q[i]]) all_rev = 1'b0;
            end
        end
    end

    // Next-state and game datapath.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        len_d     = len_q;
        miss_d    = miss_q;
        guessed_d = guessed_q;
        hcand_d   = hcand_q;
        pcand_d   = pcand_q;
        do_clear  = 1'b0;
        if (error) begin
            do_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_SETUP: begin
                    if (h_evt[KEY_UP]) begin
                        hcand_d = ltr_inc(hcand_q);
                    end else if (h_evt[KEY_DOWN]) begin
                        hcand_d = ltr_dec(hcand_q);
                    end else if (h_evt[KEY_ENTER]) begin
                        if (len_q < LEN_W'(MAX_LEN)) begin
                            word_d[len_q[IDX_W-1:0]] = hcand_q;
                            len_d   = LEN_W'(len_q + 1'b1);
                            hcand_d = '0;
                        end
                    end else if (h_evt[KEY_WORD]) begin
                        if (len_q != '0) begin
                            state_d   = ST_PLAY;
                            miss_d    = '0;
                            guessed_d = '0;
                        end
                    end
                end
                ST_PLAY: begin
                    if (all_rev) begin
                        state_d = ST_WIN;
                    end else if (miss_q >= MISS_W'(MAX_MISS)) begin
                        state_d = ST_LOSE;
                    end else if (p_evt[KEY_UP]) begin
                        pcand_d = ltr_inc(pcand_q);
                    end else if (p_evt[KEY_DOWN]) begin
                        pcand_d = ltr_dec(pcand_q);
                    end else if (p_evt[KEY_ENTER] && !guessed_q[pcand_q]) begin
                        guessed_d[pcand_q] = 1'b1;
                        if (!in_word) miss_d = MISS_W'(miss_q + 1'b1);
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (p_evt[KEY_WORD]) do_clear = 1'b1;
                end
                default: do_clear = 1'b1;
            endcase
        end
        if (do_clear) begin
            state_d   = ST_SETUP;
            word_d    = '0;
            len_d     = '0;
            miss_d    = '0;
            guessed_d = '0;
            hcand_d   = '0;
            pcand_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= ST_SETUP;
            word_q    <= '0;
            len_q     <= '0;
            miss_q    <= '0;
            guessed_q <= '0;
            hcand_q   <= '0;
            pcand_q   <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            len_q     <= len_d;
            miss_q    <= miss_d;
            guessed_q <= guessed_d;
            hcand_q   <= hcand_d;
            pcand_q   <= pcand_d;
        end
    end

    // Display decode; char0 of each row sits in bits [127:120].
    logic [7:0] miss_digit;
    assign miss_digit = 8'(8'h30 + {5'b00000, miss_q});

    always_comb begin
        host_row1 = {16{8'h20}};
        host_row2 = {16{8'h20}};
        play_row1 = {16{8'h20}};
        play_row2 = {16{8'h20}};

        host_row1[ROW_W-1 -: 40] = "WORD:";
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (LEN_W'(i) < len_q) host_row1[87-8*i -: 8] = ascii(word_q[i]);
        end

        host_row2[ROW_W-1 -: 32] = "LTR:";
        host_row2[95 -: 8]       = ascii(hcand_q);
        host_row2[87 -: 48]      = " MISS:";
        host_row2[39 -: 8]       = miss_digit;

        if (state_q != ST_SETUP) begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                if (LEN_W'(i) < len_q) begin
                    play_row1[ROW_W-1-8*i -: 8] = guessed_q[word_q[i]] ? ascii(word_q[i]) : 8'h5F;
                end
            end
        end

        unique case (state_q)
            ST_WIN:  play_row2[ROW_W-1 -: 56] = "YOU WIN";
            ST_LOSE: play_row2[ROW_W-1 -: 64] = "YOU LOSE";
            default: begin
                play_row2[ROW_W-1 -: 48] = "GUESS:";
                play_row2[79 -: 8]       = ascii(pcand_q);
                play_row2[71 -: 48]      = " MISS:";
                play_row2[23 -: 8]       = miss_digit;
            end
        endcase
    end

endmodule

// File: tb/tb_main.sv
// Scoreboard bench for the word-guessing game: stimulus queues expected display rows,
// a monitor process compares them against the DUT outputs.
module tb_main;

    logic         clk;
    logic         nRst;
    logic         role_switch;
    logic [3:0]   input_row_host;
    logic [3:0]   input_row_player;
    logic         error;
    logic         red, green, blue;
    logic [127:0] host_row1, host_row2, play_row1, play_row2;

    main dut (
        .clk              (clk),
        .nRst             (nRst),
        .role_switch      (role_switch),
        .input_row_host   (input_row_host),
        .input_row_player (input_row_player),
        .error            (error),
        .red              (red),
        .green            (green),
        .blue             (blue),
        .host_row1        (host_row1),
        .host_row2        (host_row2),
        .play_row1        (play_row1),
        .play_row2        (play_row2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_UP = 3, K_DOWN = 2, K_WORD = 1, K_ENTER = 0;
    localparam int HOST = 0, PLAYER = 1;

    typedef struct {
        string             name;
        logic [3:0][127:0] rows;
    } exp_t;

    exp_t exp_q[$];
    int   n_total  = 0;
    int   n_passed = 0;

    function automatic logic [127:0] pad16(input string s);
        logic [127:0] r;
        r = {16{8'h20}};
        for (int i = 0; i < s.len() && i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    // Monitor: compares the oldest expectation against the live rows.
    initial begin
        exp_t              it;
        logic [3:0][127:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                it  = exp_q.pop_front();
                act = {host_row1, host_row2, play_row1, play_row2};
                for (int j = 3; j >= 0; j--) begin
                    n_total++;
                    if (act[j] === it.rows[j]) n_passed++;
                    else $display("FAIL %s row%0d: got '%s' expected '%s'",
                                  it.name, 3 - j, act[j], it.rows[j]);
                end
            end
        end
    end

    task automatic expect_rows(input string nm, input string a, input string b,
                               input string c, input string d);
        exp_t it;
        it.name = nm;
        it.rows = {pad16(a), pad16(b), pad16(c), pad16(d)};
        exp_q.push_back(it);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL %s: monitor did not consume expectation, queue=%0d required 0",
                     nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic expect_reset(input string nm);
        expect_rows(nm, "WORD:", "LTR:A MISS:0", "", "GUESS:A MISS:0");
    endtask

    task automatic press(input int bus, input int k, input int hold);
        @(negedge clk);
        if (bus == HOST) input_row_host = 4'(1 << k);
        else             input_row_player = 4'(1 << k);
        repeat (hold) @(negedge clk);
        input_row_host   = 4'h0;
        input_row_player = 4'h0;
        repeat (24) @(negedge clk);
    endtask

    task automatic hkey(input int k);
        press(HOST, k, 24);
    endtask

    task automatic pkey(input int k);
        press(PLAYER, k, 24);
    endtask

    task automatic host_letter(input int n);
        repeat (n) hkey(K_UP);
        hkey(K_ENTER);
    endtask

    task automatic player_ups(input int n);
        repeat (n) pkey(K_UP);
    endtask

    task automatic pulse_error;
        @(negedge clk);
        error = 1'b1;
        @(negedge clk);
        error = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        nRst = 1'b0; role_switch = 1'b0; error = 1'b0;
        input_row_host = 4'h0; input_row_player = 4'h0;
        red = 1'b0; green = 1'b1; blue = 1'b0;
        repeat (4) @(negedge clk);
        nRst = 1'b1;
        repeat (2) @(negedge clk);

        expect_reset("reset");

        // Single UP then ENTER, then a too-short glitch
        hkey(K_UP);
        expect_rows("up_b", "WORD:", "LTR:B MISS:0", "", "GUESS:A MISS:0");
        hkey(K_ENTER);
        expect_rows("enter_b", "WORD:B", "LTR:A MISS:0", "", "GUESS:A MISS:0");
        press(HOST, K_UP, 10);
        expect_rows("glitch", "WORD:B", "LTR:A MISS:0", "", "GUESS:A MISS:0");

        // Candidate wrap in both directions
        hkey(K_DOWN);
        expect_rows("wrap_down", "WORD:B", "LTR:Z MISS:0", "", "GUESS:A MISS:0");
        hkey(K_UP);
        expect_rows("wrap_up", "WORD:B", "LTR:A MISS:0", "", "GUESS:A MISS:0");

        pulse_error();
        expect_reset("error_setup");

        // Enter APPLE; player keys are ignored in SETUP
        host_letter(0); host_letter(15); host_letter(15); host_letter(11); host_letter(4);
        pkey(K_UP);
        expect_rows("apple", "WORD:APPLE", "LTR:A MISS:0", "", "GUESS:A MISS:0");
        hkey(K_WORD);
        hkey(K_UP);
        expect_rows("play", "WORD:APPLE", "LTR:A MISS:0", "_____", "GUESS:A MISS:0");

        player_ups(15); pkey(K_ENTER);
        expect_rows("guess_p", "WORD:APPLE", "LTR:A MISS:0", "_PP__", "GUESS:P MISS:0");
        player_ups(10); pkey(K_ENTER);
        expect_rows("guess_z", "WORD:APPLE", "LTR:A MISS:1", "_PP__", "GUESS:Z MISS:1");
        pkey(K_ENTER);
        expect_rows("guess_z2", "WORD:APPLE", "LTR:A MISS:1", "_PP__", "GUESS:Z MISS:1");
        player_ups(1); pkey(K_ENTER);
        expect_rows("guess_a", "WORD:APPLE", "LTR:A MISS:1", "APP__", "GUESS:A MISS:1");
        player_ups(11); pkey(K_ENTER);
        expect_rows("guess_l", "WORD:APPLE", "LTR:A MISS:1", "APPL_", "GUESS:L MISS:1");
        repeat (7) pkey(K_DOWN);
        pkey(K_ENTER);
        expect_rows("win", "WORD:APPLE", "LTR:A MISS:1", "APPLE", "YOU WIN");
        pkey(K_WORD);
        expect_reset("restart_win");

        // WORD at length 0 ignored; ninth letter ignored
        hkey(K_WORD);
        repeat (9) hkey(K_ENTER);
        expect_rows("len8", "WORD:AAAAAAAA", "LTR:A MISS:0", "", "GUESS:A MISS:0");
        pulse_error();
        expect_reset("error_len8");

        hkey(K_ENTER); hkey(K_WORD);
        expect_rows("play_a", "WORD:A", "LTR:A MISS:0", "_", "GUESS:A MISS:0");
        pulse_error();
        expect_reset("error_play");

        // Six wrong guesses B..G
        hkey(K_ENTER); hkey(K_WORD);
        for (int g = 0; g < 5; g++) begin
            pkey(K_UP); pkey(K_ENTER);
        end
        expect_rows("miss5", "WORD:A", "LTR:A MISS:5", "_", "GUESS:F MISS:5");
        pkey(K_UP); pkey(K_ENTER);
        expect_rows("lose", "WORD:A", "LTR:A MISS:6", "_", "YOU LOSE");
        pkey(K_WORD);
        expect_reset("restart_lose");

        // Swapped roles: player pins act as host
        role_switch = 1'b1;
        press(PLAYER, K_UP, 24);
        press(HOST, K_UP, 24);
        expect_rows("swap", "WORD:", "LTR:B MISS:0", "", "GUESS:A MISS:0");
        role_switch = 1'b0;

        // Reset asserted mid-press; release must not produce an event
        @(negedge clk);
        input_row_host = 4'(1 << K_UP);
        repeat (8) @(negedge clk);
        nRst = 1'b0;
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        repeat (5) @(negedge clk);
        input_row_host = 4'h0;
        repeat (30) @(negedge clk);
        expect_reset("reset_mid_press");

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 SHALL have the port clk, an input of width 1: the single system clock; all state updates on its rising edge.
REQ-002 SHALL have the port nRst, an input of width 1: reset, asynchronous and active-low.
REQ-003 SHALL have the port role_switch, an input of width 1: 0 = input_row_host is host keypad and input_row_player is player keypad; 1 = the two are swapped.
REQ-004 SHALL have the port input_row_host, an input of width 4: host keypad lines, one-hot per key (bit3 UP, bit2 DOWN, bit1 WORD, bit0 ENTER).
REQ-005 SHALL have the port input_row_player, an input of width 4: player keypad lines, same key map (bit1 = RESTART).
REQ-006 SHALL have the port error, an input of width 1: external abort; high for one or more cycles returns the game to SETUP.
REQ-007 SHALL have the ports red, green and blue, inputs of width 1 each: reserved LED-feedback inputs with no effect on function.
REQ-008 SHALL have the port host_row1, an output of width 128: 16 ASCII characters; char0 is [127:120].
REQ-009 SHALL have the ports host_row2, play_row1 and play_row2, outputs of width 128 each, with the same packing as host_row1.

Function
REQ-010 SHALL pass each keypad bus through a 2-flop synchronizer.
REQ-011 SHALL accept a key when the synchronized value is one-hot and stable for 16 consecutive cycles.
REQ-012 SHALL emit exactly one key event per accepted press.
REQ-013 SHALL re-arm a keypad only after its bus reads 0 for 16 consecutive cycles.
REQ-014 SHALL ignore non-one-hot values.
REQ-015 SHALL apply a key event on the cycle after acceptance.
REQ-016 SHALL keep a host candidate letter and a player candidate letter, each 'A'..'Z' (5-bit index).
REQ-017 SHALL make UP increment the candidate letter, wrapping Z->A.
REQ-018 SHALL make DOWN decrement the candidate letter, wrapping A->Z.
REQ-019 SHALL have states SETUP, PLAY, WIN and LOSE.
REQ-020 SHALL make host ENTER in SETUP append the host candidate to the word if length<8, then reset the candidate to 'A'; at length 8 it is ignored.
REQ-021 SHALL make host WORD in SETUP go to PLAY if length>=1; at length 0 it is ignored.
REQ-022 SHALL, on entering PLAY, set misses to 0 and clear the guessed-letter set (26 bits).
REQ-023 SHALL make player ENTER in PLAY submit the player candidate.
REQ-024 SHALL ignore a guess already in the guessed-letter set (no miss added).
REQ-025 SHALL otherwise add the guess to the set and increment misses if it is absent from the word.
REQ-026 SHALL go to WIN when all word positions are revealed, evaluated the cycle after the guess.
REQ-027 SHALL go to LOSE when misses reach 6; win is checked first.
REQ-028 SHALL make player RESTART in WIN or LOSE go to SETUP, clearing the word, length, misses, guessed set and both candidates to 'A'.
REQ-029 SHALL ignore keys invalid for the current state.
REQ-030 SHALL ignore all player keys in SETUP and all host keys in PLAY, WIN and LOSE.
REQ-031 SHALL give error=1 the same clearing effect as RESTART in any state, with priority over key events in the same cycle.
REQ-032 SHALL drive host_row1 as "WORD:" followed by the entered letters, space-padded to 16.
REQ-033 SHALL drive host_row2 as "LTR:x MISS:n", where x is the host candidate and n is the ASCII digit of misses, space-padded.
REQ-034 SHALL drive play_row1 with word positions 0..length-1, each shown as its letter if guessed or '_' otherwise, space-padded; it is all spaces in SETUP.
REQ-035 SHALL drive play_row2 as "GUESS:x MISS:n" in SETUP and PLAY, "YOU WIN" in WIN and "YOU LOSE" in LOSE, space-padded.
REQ-036 SHALL decode the display outputs combinationally from registered state, valid the cycle after any state change.
REQ-037 SHALL, when role_switch changes mid-game, take effect on the next accepted event; a press already in debounce continues on its physical bus.

Reset
REQ-038 SHALL, while nRst=0, immediately set: state SETUP, word empty, length 0, misses 0, guessed set 0, both candidates 'A', and debounce counters and arm flags cleared and armed.
REQ-039 SHALL make the outputs after reset: host_row1="WORD:" padded, host_row2="LTR:A MISS:0" padded, play_row1 all spaces (0x20), play_row2="GUESS:A MISS:0" padded.

Verification
REQ-040 SHALL pass this scenario: reset -> the four rows show exactly the REQ-039 strings.
REQ-041 SHALL pass this scenario: host UP held 16+ cycles, released, ENTER -> host_row1="WORD:B"; a 10-cycle glitch on UP -> no change.
REQ-042 SHALL pass this scenario: host enters A,P,P,L,E, then WORD -> state PLAY, play_row1="_____".
REQ-043 SHALL pass this scenario: player guesses P -> play_row1="_PP__", MISS:0; guesses Z -> MISS:1; guesses Z again -> MISS:1.
REQ-044 SHALL pass this scenario: guesses A, L, E after REQ-043 -> play_row2="YOU WIN"; RESTART -> REQ-039 strings.
REQ-045 SHALL pass this scenario: six distinct wrong guesses -> "YOU LOSE"; error pulse in PLAY -> SETUP; nRst low mid-press -> reset values and no event on release.
